// File: rtl/acs_pm_bank.sv
// acs_pm_bank: add-compare-select + path-metric bank, rate-1/2 K=4 Viterbi.
// Optional build macro ACS_NORM_EN: MSB-clear metric renormalisation.
//
// Ports:
//   clk, rst (sync, active-high)
//   bm_valid, frame_start       : symbol strobe / new-frame qualifier
//   bm00, bm01, bm10, bm11      : branch metrics per expected {c1,c0}
//   dec[7:0]                    : survivor bit per next-state (1 = p1)
//   best_state[2:0]             : index of lowest updated metric
//   dec_valid                   : dec/best_state updated this cycle
//   pm_sat                      : sticky metric-clip flag
module acs_pm_bank #(
    parameter int         PM_W    = 8,
    parameter int         INIT_PM = 16,
    parameter logic [3:0] G0      = 4'b1101,
    parameter logic [3:0] G1      = 4'b1011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bm_valid,
    input  logic       frame_start,
    input  logic [1:0] bm00,
    input  logic [1:0] bm01,
    input  logic [1:0] bm10,
    input  logic [1:0] bm11,
    output logic [7:0] dec,
    output logic [2:0] best_state,
    output logic       dec_valid,
    output logic       pm_sat
);

    localparam logic [PM_W:0]   SAT_V = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    logic [PM_W-1:0] r_pm [8];
    logic [7:0]      r_dec;
    logic [2:0]      r_best;
    logic            r_dv;
    logic            r_sat;

    logic [PM_W-1:0] w_pre [8];
    logic [PM_W-1:0] w_sum [8];
    logic [PM_W-1:0] w_new [8];
    logic [7:0]      w_dec;
    logic [2:0]      w_best;
    logic            w_clip;

    // Branch metric for transition with register contents r = {u, s}.
    function automatic logic [1:0] f_bm(input logic [3:0] r);
        logic [1:0] c;
        c = {^(r & G1), ^(r & G0)};
        case (c)
            2'b00:   return bm00;
            2'b01:   return bm01;
            2'b10:   return bm10;
            default: return bm11;
        endcase
    endfunction

    // A frame start replaces the stored metrics as the starting point.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (bm_valid && frame_start)
                w_pre[i] = (i == 0) ? '0 : INIT_V;
            else
                w_pre[i] = r_pm[i];
        end
    end

    always_comb begin
        logic [2:0]    v_ns;
        logic [2:0]    v_p0;
        logic [2:0]    v_p1;
        logic [PM_W:0] v_c0;
        logic [PM_W:0] v_c1;
        logic [PM_W:0] v_sel;
        w_clip = 1'b0;
        w_dec  = '0;
        for (int n = 0; n < 8; n++) begin
            v_ns = 3'(n);
            v_p0 = {1'b0, v_ns[2:1]};
            v_p1 = {1'b1, v_ns[2:1]};
            v_c0 = {1'b0, w_pre[v_p0]}
                 + {{(PM_W-1){1'b0}}, f_bm({v_ns[0], v_p0})};
            v_c1 = {1'b0, w_pre[v_p1]}
                 + {{(PM_W-1){1'b0}}, f_bm({v_ns[0], v_p1})};
            // Strict compare: ties keep p0.
            w_dec[n] = (v_c1 < v_c0);
            v_sel    = w_dec[n] ? v_c1 : v_c0;
            if (v_sel > SAT_V) begin
                w_clip   = 1'b1;
                w_sum[n] = SAT_V[PM_W-1:0];
            end else begin
                w_sum[n] = v_sel[PM_W-1:0];
            end
        end
    end

`ifdef ACS_NORM_EN
    // Subtract 2^(PM_W-1) from every metric once all of them exceed it.
    always_comb begin
        logic v_all;
        v_all = 1'b1;
        for (int i = 0; i < 8; i++)
            v_all = v_all & w_sum[i][PM_W-1];
        for (int i = 0; i < 8; i++) begin
            w_new[i] = w_sum[i];
            if (v_all)
                w_new[i][PM_W-1] = 1'b0;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 8; i++)
            w_new[i] = w_sum[i];
    end
`endif

    // Strict less-than scan keeps the lowest index on equal minima.
    always_comb begin
        w_best = 3'd0;
        for (int i = 1; i < 8; i++)
            if (w_new[i] < w_new[w_best])
                w_best = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                r_pm[i] <= (i == 0) ? '0 : INIT_V;
            r_dec  <= '0;
            r_best <= '0;
            r_dv   <= 1'b0;
            r_sat  <= 1'b0;
        end else begin
            r_dv <= bm_valid;
            if (bm_valid) begin
                for (int i = 0; i < 8; i++)
                    r_pm[i] <= w_new[i];
                r_dec  <= w_dec;
                r_best <= w_best;
                if (w_clip)
                    r_sat <= 1'b1;
            end
        end
    end

    assign dec        = r_dec;
    assign best_state = r_best;
    assign dec_valid  = r_dv;
    assign pm_sat     = r_sat;

endmodule

// File: tb/tb_acs_pm_bank.sv
// tb_acs_pm_bank: directed vector bench for acs_pm_bank.
// Table of symbols with hand-derived expectations plus a long noise run.
module tb_acs_pm_bank;

    typedef struct {
        logic       r;
        logic       v;
        logic       fs;
        logic [1:0] b00;
        logic [1:0] b01;
        logic [1:0] b10;
        logic [1:0] b11;
        logic [7:0] edec;
        logic [7:0] mask;
        logic [2:0] ebest;
        logic       edv;
        logic       pz;
    } vec_t;

    // Encoder trace for input 1,0,1,1,0,0,1,0: received {c1,c0},
    // encoder state after each bit, and predecessor MSB (decision).
    localparam logic [1:0] ENC_RX [8] =
        '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b11};
    localparam logic [2:0] ENC_NS [8] =
        '{3'd1, 3'd2, 3'd5, 3'd3, 3'd6, 3'd4, 3'd1, 3'd2};
    localparam logic ENC_D [8] =
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

`ifdef ACS_NORM_EN
    localparam logic       EXP_SAT = 1'b0;
    localparam logic [7:0] EXP_PM  = 8'd16;
`else
    localparam logic       EXP_SAT = 1'b1;
    localparam logic [7:0] EXP_PM  = 8'd255;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bm_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] bm00 = '0;
    logic [1:0] bm01 = '0;
    logic [1:0] bm10 = '0;
    logic [1:0] bm11 = '0;
    logic [7:0] dec;
    logic [2:0] best_state;
    logic       dec_valid;
    logic       pm_sat;

    int n_run  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    acs_pm_bank dut (
        .clk        (clk),
        .rst        (rst),
        .bm_valid   (bm_valid),
        .frame_start(frame_start),
        .bm00       (bm00),
        .bm01       (bm01),
        .bm10       (bm10),
        .bm11       (bm11),
        .dec        (dec),
        .best_state (best_state),
        .dec_valid  (dec_valid),
        .pm_sat     (pm_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pc(input logic [1:0] x);
        return 2'(x[1]) + 2'(x[0]);
    endfunction

    task automatic add(input logic r, v, fs,
                       input logic [1:0] b00, b01, b10, b11,
                       input logic [7:0] ed, m,
                       input logic [2:0] eb,
                       input logic edv, pz);
        vec_t t;
        t.r = r; t.v = v; t.fs = fs;
        t.b00 = b00; t.b01 = b01; t.b10 = b10; t.b11 = b11;
        t.edec = ed; t.mask = m; t.ebest = eb;
        t.edv = edv; t.pz = pz;
        tbl.push_back(t);
    endtask

    // Exact received symbol: metric = Hamming distance to each pattern.
    task automatic add_enc(input int k, input logic fs);
        logic [1:0] rx;
        logic [7:0] m;
        rx = ENC_RX[k];
        m  = 8'b1 << ENC_NS[k];
        add(1'b0, 1'b1, fs,
            pc(rx ^ 2'b00), pc(rx ^ 2'b01),
            pc(rx ^ 2'b10), pc(rx ^ 2'b11),
            ENC_D[k] ? m : 8'h00, m, ENC_NS[k], 1'b1, 1'b0);
    endtask

    task automatic add_tie(input int step);
        case (step)
            0: add(0, 1, 1, 2'd1, 2'd1, 2'd1, 2'd1,
                   8'h00, 8'hff, 3'd0, 1, 0);
            1: add(0, 1, 0, 2'd2, 2'd1, 2'd1, 2'd0,
                   8'h90, 8'hff, 3'd1, 1, 0);
            default: add(0, 1, 0, 2'd2, 2'd1, 2'd2, 2'd1,
                   8'h00, 8'hff, 3'd2, 1, 0);
        endcase
    endtask

    initial begin
        // Reset state, including rst overriding bm_valid/frame_start.
        add(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'hff, 3'd0, 0, 0);
        add(1, 1, 1, 2, 2, 2, 2, 8'h00, 8'hff, 3'd0, 0, 0);
        // Clean channel: state 0 stays at metric 0.
        for (int k = 0; k < 8; k++)
            add(0, 1, k == 0, 2'd0, 2'd1, 2'd1, 2'd2,
                8'h00, 8'h01, 3'd0, 1, 1);
        // Encoded stream, unbroken.
        for (int k = 0; k < 8; k++)
            add_enc(k, k == 0);
        // Same stream with a 3-cycle gap; lone frame_start ignored.
        for (int k = 0; k < 4; k++)
            add_enc(k, k == 0);
        for (int k = 0; k < 3; k++)
            add(0, 0, k == 0, 0, 0, 0, 0, 8'h08, 8'h08, 3'd3, 0, 0);
        for (int k = 4; k < 8; k++)
            add_enc(k, 1'b0);
        // Tie handling: ends with equal minima at states 2 and 5.
        for (int k = 0; k < 3; k++)
            add_tie(k);
        // Reset mid-frame, then a fresh frame must repeat the results.
        add_tie(0);
        add_tie(1);
        add(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'hff, 3'd0, 0, 0);
        for (int k = 0; k < 3; k++)
            add_tie(k);

        foreach (tbl[i]) begin
            rst         = tbl[i].r;
            bm_valid    = tbl[i].v;
            frame_start = tbl[i].fs;
            bm00 = tbl[i].b00;
            bm01 = tbl[i].b01;
            bm10 = tbl[i].b10;
            bm11 = tbl[i].b11;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dv", i), 32'(dec_valid), 32'(tbl[i].edv));
            chk($sformatf("v%0d_best", i), 32'(best_state),
                32'(tbl[i].ebest));
            chk($sformatf("v%0d_dec", i), 32'(dec & tbl[i].mask),
                32'(tbl[i].edec));
            if (tbl[i].pz)
                chk($sformatf("v%0d_pm0", i), 32'(dut.r_pm[0]), 32'd0);
        end

        // 200 symbols of all-metric-2 noise: metrics converge to equal.
        rst = 1'b0;
        bm00 = 2'd2; bm01 = 2'd2; bm10 = 2'd2; bm11 = 2'd2;
        bm_valid = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            frame_start = (k == 1);
            @(posedge clk);
            #1;
            chk($sformatf("noise%0d_dec", k), 32'(dec), 32'd0);
            chk($sformatf("noise%0d_best", k), 32'(best_state), 32'd0);
            if (k == 127)
                chk("sat_k127", 32'(pm_sat), 32'd0);
            if (k == 128)
                chk("sat_k128", 32'(pm_sat), 32'(EXP_SAT));
        end
        bm_valid = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_end", 32'(pm_sat), 32'(EXP_SAT));
        chk("dv_idle", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("noise_pm%0d", i), 32'(dut.r_pm[i]),
                32'(EXP_PM));

        // Sticky flag clears only on reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_rst", 32'(pm_sat), 32'd0);
        chk("pm1_rst", 32'(dut.r_pm[1]), 32'd16);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
